// File: rtl/riscv_pipeline_ctrl.sv
// Hazard and stall controller for the RV32I five-stage core: load-use bubbles,
// taken-branch flushes, data-memory wait states with timeout fault, stall counting.
module riscv_pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    input  logic             i_fault_clr,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_ifid_clr,
    output logic             o_idex_clr,
    output logic             o_exmem_clr,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FAULT
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       tmo_cnt;
    logic [7:0]       tmo_cnt_nxt;
    logic             fault_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             lu;
    logic             rs1_hit;
    logic             rs2_hit;

    // Flow-control strobes for the hazard rules shared by RUN and the MEM_WAIT ack cycle.
    logic flow_pc_en;
    logic flow_ifid_en;
    logic flow_idex_en;
    logic flow_exmem_en;
    logic flow_ifid_clr;
    logic flow_idex_clr;

    assign rs1_hit = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign rs2_hit = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    assign lu      = i_ex_mem_read && (i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_RUN;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        case (state)
            ST_RUN: begin
                if (i_mem_req && !i_mem_ack) begin
                    state_nxt   = ST_MEM_WAIT;
                    tmo_cnt_nxt = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                // A late ack still wins over the timeout in the same cycle.
                if (i_mem_ack) begin
                    state_nxt   = ST_RUN;
                    tmo_cnt_nxt = 8'd0;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    state_nxt   = ST_FAULT;
                    tmo_cnt_nxt = 8'd0;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            ST_FAULT: begin
                if (i_fault_clr) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt   = ST_RUN;
                tmo_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_comb begin
        flow_pc_en    = 1'b1;
        flow_ifid_en  = 1'b1;
        flow_idex_en  = 1'b1;
        flow_exmem_en = 1'b1;
        flow_ifid_clr = 1'b0;
        flow_idex_clr = 1'b0;
        if (i_ex_br_taken) begin
            flow_ifid_clr = 1'b1;
            flow_idex_clr = 1'b1;
        end else if (lu) begin
            flow_pc_en    = 1'b0;
            flow_ifid_en  = 1'b0;
            flow_idex_clr = 1'b1;
        end
    end

    always_comb begin
        o_pc_en     = 1'b0;
        o_ifid_en   = 1'b0;
        o_idex_en   = 1'b0;
        o_exmem_en  = 1'b0;
        o_ifid_clr  = 1'b0;
        o_idex_clr  = 1'b0;
        o_exmem_clr = 1'b0;
        if (!i_rstn) begin
            o_ifid_clr  = 1'b1;
            o_idex_clr  = 1'b1;
            o_exmem_clr = 1'b1;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    // In RUN a pending memory miss freezes everything; in MEM_WAIT only ack releases.
                    if ((state == ST_RUN && !(i_mem_req && !i_mem_ack)) ||
                        (state == ST_MEM_WAIT && i_mem_ack)) begin
                        o_pc_en    = flow_pc_en;
                        o_ifid_en  = flow_ifid_en;
                        o_idex_en  = flow_idex_en;
                        o_exmem_en = flow_exmem_en;
                        o_ifid_clr = flow_ifid_clr;
                        o_idex_clr = flow_idex_clr;
                    end
                end
                ST_FAULT: begin
                    if (i_fault_clr) begin
                        o_ifid_clr  = 1'b1;
                        o_idex_clr  = 1'b1;
                        o_exmem_clr = 1'b1;
                    end
                end
                default: begin
                    o_pc_en = 1'b0;
                end
            endcase
        end
    end

    // Fault flag follows FAULT entry/exit on the same edges as the state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fault_q   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            fault_q <= (state_nxt == ST_FAULT);
            if (!o_pc_en && (state != ST_FAULT) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fault     = fault_q;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// Directed self-checking bench: dut_a uses default parameters, dut_b uses
// MEM_TIMEOUT=4 and CNT_W=4 for timeout and saturation corners.
module tb_riscv_pipeline_ctrl;

    logic       i_clk;
    logic       i_rstn;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_rs1_used;
    logic       i_id_rs2_used;
    logic [4:0] i_ex_rd;
    logic       i_ex_mem_read;
    logic       i_ex_br_taken;
    logic       i_mem_req;
    logic       i_mem_ack;
    logic       i_fault_clr;

    logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en;
    logic        a_ifid_clr, a_idex_clr, a_exmem_clr, a_fault;
    logic [15:0] a_stall_cnt;
    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en;
    logic        b_ifid_clr, b_idex_clr, b_exmem_clr, b_fault;
    logic [3:0]  b_stall_cnt;

    logic [6:0] ctrl_a;
    logic [6:0] ctrl_b;

    int tests_run;
    int tests_failed;

    // Packed as {pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, exmem_clr}
    localparam logic [6:0] C_RESET  = 7'b0000_111;
    localparam logic [6:0] C_FLOW   = 7'b1111_000;
    localparam logic [6:0] C_LU     = 7'b0011_010;
    localparam logic [6:0] C_BRANCH = 7'b1111_110;
    localparam logic [6:0] C_FREEZE = 7'b0000_000;
    localparam logic [6:0] C_FCLR   = 7'b0000_111;

    assign ctrl_a = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_ifid_clr, a_idex_clr, a_exmem_clr};
    assign ctrl_b = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_ifid_clr, b_idex_clr, b_exmem_clr};

    riscv_pipeline_ctrl dut_a (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_br_taken(i_ex_br_taken),
        .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack), .i_fault_clr(i_fault_clr),
        .o_pc_en(a_pc_en), .o_ifid_en(a_ifid_en), .o_idex_en(a_idex_en), .o_exmem_en(a_exmem_en),
        .o_ifid_clr(a_ifid_clr), .o_idex_clr(a_idex_clr), .o_exmem_clr(a_exmem_clr),
        .o_fault(a_fault), .o_stall_cnt(a_stall_cnt)
    );

    riscv_pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_br_taken(i_ex_br_taken),
        .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack), .i_fault_clr(i_fault_clr),
        .o_pc_en(b_pc_en), .o_ifid_en(b_ifid_en), .o_idex_en(b_idex_en), .o_exmem_en(b_exmem_en),
        .o_ifid_clr(b_ifid_clr), .o_idex_clr(b_idex_clr), .o_exmem_clr(b_exmem_clr),
        .o_fault(b_fault), .o_stall_cnt(b_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic rs1u, input logic rs2u,
                                 input logic [4:0] exrd, input logic memrd, input logic br,
                                 input logic req, input logic ack, input logic fclr);
        i_id_rs1      = rs1;
        i_id_rs2      = rs2;
        i_id_rs1_used = rs1u;
        i_id_rs2_used = rs2u;
        i_ex_rd       = exrd;
        i_ex_mem_read = memrd;
        i_ex_br_taken = br;
        i_mem_req     = req;
        i_mem_ack     = ack;
        i_fault_clr   = fclr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulseReset();
        i_rstn = 1'b0;
        idle();
        i_rstn = 1'b1;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset values
        i_rstn = 1'b0;
        idle();
        checkOutput("reset_ctrl_a", 32'(ctrl_a), 32'(C_RESET));
        checkOutput("reset_ctrl_b", 32'(ctrl_b), 32'(C_RESET));
        checkOutput("reset_fault_a", 32'(a_fault), 32'd0);
        checkOutput("reset_cnt_a", 32'(a_stall_cnt), 32'd0);
        tick();
        tick();
        checkOutput("reset_hold_ctrl_a", 32'(ctrl_a), 32'(C_RESET));
        i_rstn = 1'b1;
        #1;
        checkOutput("release_ctrl_a", 32'(ctrl_a), 32'(C_FLOW));
        checkOutput("release_ctrl_b", 32'(ctrl_b), 32'(C_FLOW));
        tick();
        checkOutput("release_cnt_a", 32'(a_stall_cnt), 32'd0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs1_ctrl", 32'(ctrl_a), 32'(C_LU));
        tick();
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_bubble_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        checkOutput("lu_cnt", 32'(a_stall_cnt), 32'd1);
        applyStimulus(5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rd0_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        tick();
        checkOutput("lu_rd0_cnt", 32'(a_stall_cnt), 32'd1);
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_ctrl", 32'(ctrl_b), 32'(C_LU));
        tick();
        idle();
        checkOutput("lu_rs2_cnt", 32'(a_stall_cnt), 32'd2);

        // Taken branch overrides load-use
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("branch_lu_ctrl", 32'(ctrl_a), 32'(C_BRANCH));
        tick();
        idle();
        checkOutput("branch_cnt", 32'(a_stall_cnt), 32'd2);

        // Memory wait, ack three cycles after the request
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mem_req_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
        tick();
        checkOutput("mem_wait1_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
        tick();
        checkOutput("mem_wait2_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mem_ack_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        tick();
        idle();
        checkOutput("mem_after_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        checkOutput("mem_cnt", 32'(a_stall_cnt), 32'd5);

        // Memory wait with a branch pending: flush in the ack cycle
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("membr_req_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
        tick();
        tick();
        checkOutput("membr_wait_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("membr_ack_ctrl", 32'(ctrl_a), 32'(C_BRANCH));
        tick();
        idle();
        checkOutput("membr_cnt", 32'(a_stall_cnt), 32'd8);

        // Ack in the request cycle costs nothing
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mem_zero_ctrl", 32'(ctrl_a), 32'(C_FLOW));
        tick();
        idle();
        checkOutput("mem_zero_cnt", 32'(a_stall_cnt), 32'd8);

        // Ack arrives while a load-use is pending
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("memlu_ack_ctrl", 32'(ctrl_a), 32'(C_LU));
        tick();
        idle();
        checkOutput("memlu_cnt_a", 32'(a_stall_cnt), 32'd10);
        checkOutput("memlu_cnt_b", 32'(b_stall_cnt), 32'd10);

        // Timeout on dut_b (MEM_TIMEOUT=4)
        pulseReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("tmo_pre_fault_b", 32'(b_fault), 32'd0);
        tick();
        checkOutput("tmo_fault_b", 32'(b_fault), 32'd1);
        checkOutput("tmo_fault_ctrl_b", 32'(ctrl_b), 32'(C_FREEZE));
        checkOutput("tmo_cnt_b", 32'(b_stall_cnt), 32'd5);
        checkOutput("tmo_nofault_a", 32'(a_fault), 32'd0);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("tmo_late_ack_ctrl_b", 32'(ctrl_b), 32'(C_FREEZE));
        checkOutput("tmo_ack_ctrl_a", 32'(ctrl_a), 32'(C_FLOW));
        tick();
        checkOutput("tmo_late_ack_fault_b", 32'(b_fault), 32'd1);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fclr_ctrl_b", 32'(ctrl_b), 32'(C_FCLR));
        checkOutput("fclr_fault_b", 32'(b_fault), 32'd1);
        tick();
        idle();
        checkOutput("fclr_after_fault_b", 32'(b_fault), 32'd0);
        checkOutput("fclr_after_ctrl_b", 32'(ctrl_b), 32'(C_FLOW));
        checkOutput("fclr_after_cnt_b", 32'(b_stall_cnt), 32'd5);

        // Saturation: 20 load-use stall cycles
        pulseReset();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        checkOutput("sat_cnt_a", 32'(a_stall_cnt), 32'd20);
        checkOutput("sat_cnt_b", 32'(b_stall_cnt), 32'd15);

        // Async reset with dut_a mid-wait and dut_b mid-fault
        pulseReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("areset_pre_fault_b", 32'(b_fault), 32'd1);
        checkOutput("areset_pre_cnt_a", 32'(a_stall_cnt), 32'd6);
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("areset_ctrl_a", 32'(ctrl_a), 32'(C_RESET));
        checkOutput("areset_ctrl_b", 32'(ctrl_b), 32'(C_RESET));
        checkOutput("areset_fault_b", 32'(b_fault), 32'd0);
        checkOutput("areset_cnt_a", 32'(a_stall_cnt), 32'd0);
        checkOutput("areset_cnt_b", 32'(b_stall_cnt), 32'd0);
        idle();
        tick();
        i_rstn = 1'b1;
        #1;
        checkOutput("areset_release_ctrl_a", 32'(ctrl_a), 32'(C_FLOW));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
